// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, sent as an 8-bit LSB-first frame
// (start bit, data bits, optional parity bit, one or two stop bits). The serial line is registered.
module uart_tx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int PARITY    = 0,   // 0 none, 1 odd, 2 even
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = (CPB < 2) ? 1 : $clog2(CPB);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] DONE_AT   = CW'(CPB - 2);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  if (CPB < 2) begin : g_cpb_check
    $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          par_bit;
  logic          bit_end;

  assign bit_end  = (baud_cnt == BIT_LAST);
  assign tx_ready = (state == S_IDLE);
  assign tx_busy  = (state != S_IDLE);

  // NOTE: all state updates use non-blocking assignments, so every branch below reads
  // the values from before the edge, and a reset with rst_n low takes precedence over the handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state == S_IDLE || bit_end) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          tx      <= 1'b1;
          bit_idx <= '0;
          if (tx_valid) begin
            shift   <= tx_data;
            // Parity comes from the whole byte, so compute it before the shifts consume the byte.
            par_bit <= (PARITY == 1) ? ~^tx_data : ^tx_data;
            tx      <= 1'b0;
            state   <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            tx      <= shift[0];
            bit_idx <= '0;
            state   <= S_DATA;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                tx    <= par_bit;
                state <= S_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            tx      <= 1'b1;
            bit_idx <= '0;
            state   <= S_STOP;
          end
        end

        S_STOP: begin
          tx <= 1'b1;
          // Raise tx_done one cycle early so that the registered pulse lines up with the final stop cycle.
          if (bit_idx == STOP_LAST && baud_cnt == DONE_AT) tx_done <= 1'b1;
          if (bit_end) begin
            if (bit_idx == STOP_LAST) state <= S_IDLE;
            else                      bit_idx <= bit_idx + 3'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover the no-parity, even-parity, odd-parity and
// two-stop-bit configurations at CLKS_PER_BIT=10. Line waveforms are checked on every cycle.
module tb_uart_tx;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] valid;
  logic [7:0] tx_data [4];
  logic       tx_w    [4];
  logic       ready_w [4];
  logic       busy_w  [4];
  logic       done_w  [4];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx #(
      .CLK_FREQ (1000),
      .BAUD     (100),
      .PARITY   ((g == 1) ? 2 : (g == 2) ? 1 : 0),
      .STOP_BITS((g == 3) ? 2 : 1)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .tx_data (tx_data[g]),
      .tx_valid(valid[g]),
      .tx_ready(ready_w[g]),
      .tx      (tx_w[g]),
      .tx_busy (busy_w[g]),
      .tx_done (done_w[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a byte at the falling edge; the following rising edge is the accept edge.
  task automatic start(input int u, input logic [7:0] b);
    @(negedge clk);
    check($sformatf("u%0d ready before accept", u), ready_w[u], 1'b1);
    tx_data[u] = b;
    valid[u]   = 1'b1;
    @(posedge clk);
  endtask

  // Entered just after the accept edge. Cycle k lies between accept edge + k-1 and accept edge + k,
  // and is sampled at its falling edge.
  task automatic run_frame(input int u, input logic [7:0] b, input int par, input int stops,
                           input bit keep_valid, input logic [7:0] next_data,
                           input bit pulse_valid, input int abort_at);
    logic [11:0] bits;
    logic [11:0] seen;
    int nb, f;
    nb   = 10 + ((par != 0) ? 1 : 0) + stops - 1;
    f    = nb * CPB;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = b[i];
    if (par != 0) bits[9] = (par == 2) ? ^b : ~^b;
    seen = '0;
    for (int k = 1; k <= f; k++) begin
      @(negedge clk);
      check($sformatf("u%0d tx c%0d", u, k), tx_w[u], bits[(k - 1) / CPB]);
      check($sformatf("u%0d busy c%0d", u, k), busy_w[u], 1'b1);
      check($sformatf("u%0d done c%0d", u, k), done_w[u], (k == f));
      if ((k - 1) % CPB == CPB / 2) seen[(k - 1) / CPB] = tx_w[u];
      if (k == 1) begin
        tx_data[u] = next_data;
        valid[u]   = keep_valid;
      end
      if (pulse_valid && k == 30) valid[u] = 1'b1;
      if (pulse_valid && k == 31) valid[u] = 1'b0;
      if (k == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check($sformatf("u%0d abort tx", u), tx_w[u], 1'b1);
        check($sformatf("u%0d abort busy", u), busy_w[u], 1'b0);
        check($sformatf("u%0d abort done", u), done_w[u], 1'b0);
        return;
      end
    end
    @(negedge clk);
    check($sformatf("u%0d idle tx", u), tx_w[u], 1'b1);
    check($sformatf("u%0d idle ready", u), ready_w[u], 1'b1);
    check($sformatf("u%0d idle busy", u), busy_w[u], 1'b0);
    check($sformatf("u%0d idle done", u), done_w[u], 1'b0);
    check($sformatf("u%0d decoded byte", u), seen[8:1], b);
    if (par == 2) check($sformatf("u%0d parity even", u), seen[9], 1'b0);
    if (par == 1) check($sformatf("u%0d parity odd", u), seen[9], 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    valid = 4'b0001;
    for (int i = 0; i < 4; i++) tx_data[i] = 8'h00;

    // Reset held with a valid request pending: nothing may start.
    repeat (3) begin
      @(negedge clk);
      check("reset tx", tx_w[0], 1'b1);
      check("reset busy", busy_w[0], 1'b0);
      check("reset done", done_w[0], 1'b0);
    end
    valid = 4'b0000;
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("u%0d ready after reset", i), ready_w[i], 1'b1);
      check($sformatf("u%0d tx after reset", i), tx_w[i], 1'b1);
      check($sformatf("u%0d busy after reset", i), busy_w[i], 1'b0);
    end

    // Single byte, no parity, one stop bit; tx_data toggles right after accept.
    start(0, 8'hA5);
    run_frame(0, 8'hA5, 0, 1, 1'b0, 8'h5A, 1'b0, 0);

    // 0x03 has even weight: even parity bit 0, odd parity bit 1.
    start(1, 8'h03);
    run_frame(1, 8'h03, 2, 1, 1'b0, 8'hFF, 1'b0, 0);
    start(2, 8'h03);
    run_frame(2, 8'h03, 1, 1, 1'b0, 8'hFF, 1'b0, 0);

    // Back-to-back with valid held: second accept on the single idle cycle.
    start(3, 8'h55);
    run_frame(3, 8'h55, 0, 2, 1'b1, 8'hFF, 1'b0, 0);
    @(posedge clk);
    run_frame(3, 8'hFF, 0, 2, 1'b0, 8'h00, 1'b0, 0);

    // Reset during cycle 45 aborts the frame; the line stays idle with no done pulse afterwards.
    start(0, 8'hA5);
    run_frame(0, 8'hA5, 0, 1, 1'b0, 8'h00, 1'b0, 45);
    repeat (20) begin
      @(negedge clk);
      check("post abort tx", tx_w[0], 1'b1);
      check("post abort done", done_w[0], 1'b0);
    end

    // Byte after the abort, with valid pulsed mid-frame and tx_data changed after accept.
    start(0, 8'h3C);
    run_frame(0, 8'h3C, 0, 1, 1'b0, 8'hC3, 1'b1, 0);
    repeat (5) begin
      @(negedge clk);
      check("no extra frame busy", busy_w[0], 1'b0);
      check("no extra frame tx", tx_w[0], 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
